// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch stage with a small fetch buffer
//
// A PC register drives the instruction memory address. Each cycle the
// combinational memory response (instruction plus fault flag/cause/address)
// is pushed into a FIFO of {pc, instr, exc_en, exc_code, exc_val} entries.
// Decode consumes the head entry through a valid/ready handshake. A faulting
// fetch is buffered as a NOP carrying the exception packet, and fetch then
// halts (FAULT state) until the pipeline redirects.
//
// Optional build macro:
//   IFETCH_MISALIGN_CHECK_EN - a PC with pc[1:0] != 0 is turned into a
//                              faulting entry {exc_code=0, exc_val=pc}
//                              without looking at the memory response.
//
// Parameters:
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  fetch-buffer entries (power of two, >= 2)
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   pc_addr                            fetch address to instruction memory
//   instruction                        fetched word (combinational response)
//   exc_en/exc_code/exc_val            memory fault flag, cause, address
//   redirect_en/redirect_pc            pipeline redirect and its target
//   if_ready                           decode accepts the head entry
//   if_valid                           head entry present
//   if_instr/if_pc                     head instruction and its address
//   if_exc_en/if_exc_code/if_exc_val   head exception packet
// ---------------------------------------------------------------------------
module ifetch #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] pc_addr,
    input  logic [31:0] instruction,
    input  logic        exc_en,
    input  logic [3:0]  exc_code,
    input  logic [63:0] exc_val,
    input  logic        redirect_en,
    input  logic [63:0] redirect_pc,
    input  logic        if_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_exc_en,
    output logic [3:0]  if_exc_code,
    output logic [63:0] if_exc_val
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_e;

    // Control state
    state_e             state_q, state_d;
    logic [63:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    // Buffer storage (written only on push, read at the head pointer)
    logic [63:0]        fifo_pc_q       [FIFO_DEPTH];
    logic [31:0]        fifo_instr_q    [FIFO_DEPTH];
    logic               fifo_exc_en_q   [FIFO_DEPTH];
    logic [3:0]         fifo_exc_code_q [FIFO_DEPTH];
    logic [63:0]        fifo_exc_val_q  [FIFO_DEPTH];

    // Entry being assembled this cycle
    logic [31:0]        ent_instr;
    logic               ent_exc_en;
    logic [3:0]         ent_exc_code;
    logic [63:0]        ent_exc_val;

    logic               push;
    logic               pop;

    assign pc_addr  = pc_q;
    assign if_valid = (count_q != '0);

    // Redirect wins over everything, so neither push nor pop is honoured
    // in a redirect cycle; a full buffer may still push when it pops.
    assign pop  = if_valid && if_ready && !redirect_en;
    assign push = (state_q == ST_RUN) && !redirect_en
                  && ((count_q < DEPTH_C) || pop);

    // Build the entry from the memory response; a fault replaces the
    // instruction with a NOP so decode never sees garbage bits.
    always_comb begin
        ent_exc_en   = exc_en;
        ent_exc_code = exc_code;
        ent_exc_val  = exc_val;
        ent_instr    = exc_en ? NOP_INSTR : instruction;
`ifdef IFETCH_MISALIGN_CHECK_EN
        if (pc_q[1:0] != 2'b00) begin
            ent_exc_en   = 1'b1;
            ent_exc_code = 4'd0;
            ent_exc_val  = pc_q;
            ent_instr    = NOP_INSTR;
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (redirect_en) begin
            state_d  = ST_RUN;
            pc_d     = redirect_pc;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (ent_exc_en) begin
                    // Hold the PC on the faulting address; fetch stops here.
                    state_d = ST_FAULT;
                end else begin
                    pc_d = pc_q + 64'd4;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only visible after it is written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]       <= pc_q;
            fifo_instr_q[wr_ptr_q]    <= ent_instr;
            fifo_exc_en_q[wr_ptr_q]   <= ent_exc_en;
            fifo_exc_code_q[wr_ptr_q] <= ent_exc_code;
            fifo_exc_val_q[wr_ptr_q]  <= ent_exc_val;
        end
    end

    // Head outputs are forced to zero while the buffer is empty.
    always_comb begin
        if_instr    = '0;
        if_pc       = '0;
        if_exc_en   = 1'b0;
        if_exc_code = '0;
        if_exc_val  = '0;
        if (if_valid) begin
            if_instr    = fifo_instr_q[rd_ptr_q];
            if_pc       = fifo_pc_q[rd_ptr_q];
            if_exc_en   = fifo_exc_en_q[rd_ptr_q];
            if_exc_code = fifo_exc_code_q[rd_ptr_q];
            if_exc_val  = fifo_exc_val_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// ---------------------------------------------------------------------------
// tb_ifetch -- directed self-checking bench for ifetch.
// Memory model: instruction = pc[31:0] ^ 32'hA5A5_0000; the address
// 0x80040000 responds with a fault (code 1, value = the address).
// ---------------------------------------------------------------------------
module tb_ifetch;

    localparam logic [63:0] FAULT_ADDR = 64'h0000_0000_8004_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc_addr;
    logic [31:0] instruction;
    logic        exc_en;
    logic [3:0]  exc_code;
    logic [63:0] exc_val;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;

    int n_tests = 0;
    int n_fail  = 0;

    ifetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_addr     (pc_addr),
        .instruction (instruction),
        .exc_en      (exc_en),
        .exc_code    (exc_code),
        .exc_val     (exc_val),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .if_ready    (if_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_exc_en   (if_exc_en),
        .if_exc_code (if_exc_code),
        .if_exc_val  (if_exc_val)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0000;
    endfunction

    // Combinational instruction memory
    always_comb begin
        instruction = mem_word(pc_addr);
        exc_en      = (pc_addr == FAULT_ADDR);
        exc_code    = exc_en ? 4'd1 : 4'd0;
        exc_val     = exc_en ? pc_addr : 64'd0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [63:0] tgt);
        redirect_en = 1'b1;
        redirect_pc = tgt;
        step();
        redirect_en = 1'b0;
        redirect_pc = '0;
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b1;

        // Reset state and streaming fetch
        @(negedge clk);
        check_eq("rst_valid", 64'(if_valid), 64'd0);
        check_eq("rst_pc_addr", pc_addr, 64'h8000_0000);
        check_eq("rst_if_pc", if_pc, 64'd0);
        check_eq("rst_if_instr", 64'(if_instr), 64'd0);
        rst_n = 1'b1;
        step();
        check_eq("s1_valid", 64'(if_valid), 64'd1);
        check_eq("s1_if_pc", if_pc, 64'h8000_0000);
        check_eq("s1_instr", 64'(if_instr), 64'(mem_word(64'h8000_0000)));
        step();
        check_eq("s2_if_pc", if_pc, 64'h8000_0004);
        check_eq("s2_instr", 64'(if_instr), 64'(mem_word(64'h8000_0004)));

        // Back-pressure: buffer saturates, PC freezes, drain in order
        rst_n    = 1'b0;
        if_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
        check_eq("bp_pc_addr", pc_addr, 64'h8000_0008);
        check_eq("bp_head", if_pc, 64'h8000_0000);
        if_ready = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check_eq($sformatf("drain%0d_pc", k), if_pc,
                     64'h8000_0000 + 64'(4 * k));
            check_eq($sformatf("drain%0d_valid", k), 64'(if_valid), 64'd1);
        end

        // Redirect with full buffer and pop requested
        rst_n    = 1'b0;
        if_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("full_valid", 64'(if_valid), 64'd1);
        if_ready = 1'b1;
        do_redirect(64'h8000_0100);
        check_eq("redir_valid", 64'(if_valid), 64'd0);
        check_eq("redir_if_pc", if_pc, 64'd0);
        check_eq("redir_pc_addr", pc_addr, 64'h8000_0100);
        step();
        check_eq("redir_next_valid", 64'(if_valid), 64'd1);
        check_eq("redir_next_pc", if_pc, 64'h8000_0100);

        // Memory fault packet and fetch halt
        do_redirect(FAULT_ADDR);
        step();
        check_eq("flt_valid", 64'(if_valid), 64'd1);
        check_eq("flt_exc_en", 64'(if_exc_en), 64'd1);
        check_eq("flt_code", 64'(if_exc_code), 64'd1);
        check_eq("flt_val", if_exc_val, FAULT_ADDR);
        check_eq("flt_instr", 64'(if_instr), 64'h13);
        check_eq("flt_pc_addr", pc_addr, FAULT_ADDR);
        if_ready = 1'b0;
        repeat (2) step();
        check_eq("flt_hold_pc", pc_addr, FAULT_ADDR);
        if_ready = 1'b1;
        step();
        check_eq("flt_drained", 64'(if_valid), 64'd0);
        step();
        check_eq("flt_no_push", 64'(if_valid), 64'd0);
        check_eq("flt_hold_pc2", pc_addr, FAULT_ADDR);

        // Misaligned redirect target
        if_ready = 1'b0;
        do_redirect(64'h8000_0102);
        step();
        check_eq("mis_if_pc", if_pc, 64'h8000_0102);
`ifdef IFETCH_MISALIGN_CHECK_EN
        check_eq("mis_exc_en", 64'(if_exc_en), 64'd1);
        check_eq("mis_code", 64'(if_exc_code), 64'd0);
        check_eq("mis_val", if_exc_val, 64'h8000_0102);
        check_eq("mis_instr", 64'(if_instr), 64'h13);
        check_eq("mis_pc_addr", pc_addr, 64'h8000_0102);
`else
        check_eq("mis_exc_en", 64'(if_exc_en), 64'd0);
        check_eq("mis_instr", 64'(if_instr), 64'(mem_word(64'h8000_0102)));
        check_eq("mis_pc_addr", pc_addr, 64'h8000_0106);
`endif

        // Mid-stream reset with two entries and a pending FAULT
        do_redirect(FAULT_ADDR - 64'd4);
        repeat (2) step();
        check_eq("pre_rst_valid", 64'(if_valid), 64'd1);
        check_eq("pre_rst_head", if_pc, FAULT_ADDR - 64'd4);
        step();
        check_eq("pre_rst_pc_addr", pc_addr, FAULT_ADDR);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(if_valid), 64'd0);
        check_eq("mid_rst_pc_addr", pc_addr, 64'h8000_0000);
        check_eq("mid_rst_instr", 64'(if_instr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("post_rst_pc", if_pc, 64'h8000_0000);
        check_eq("post_rst_valid", 64'(if_valid), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the fetch-buffer entry count (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_addr  output  64  fetch address driven to instruction memory.
REQ-006 SHALL have port instruction  input  32  fetched word, combinational response to pc_addr.
REQ-007 SHALL have ports exc_en/exc_code/exc_val  input  1/4/64  memory fault flag, cause, faulting address.
REQ-008 SHALL have port redirect_en  input  1  pipeline redirect (branch, jump, trap, mret).
REQ-009 SHALL have port redirect_pc  input  64  redirect target.
REQ-010 SHALL have port if_ready  input  1  decode accepts head entry.
REQ-011 SHALL have port if_valid  output  1  head entry present.
REQ-012 SHALL have ports if_instr/if_pc  output  32/64  head instruction and its address.
REQ-013 SHALL have ports if_exc_en/if_exc_code/if_exc_val  output  1/4/64  head exception packet.

Function
REQ-014 SHALL hold a PC register driving pc_addr and a FIFO of {pc, instr, exc_en, exc_code, exc_val} entries.
REQ-015 SHALL implement states RUN and FAULT; FAULT means a faulting entry was pushed and fetch is halted.
REQ-016 Push SHALL occur in RUN when no redirect and (count<FIFO_DEPTH or pop this cycle); push stores pc_addr, instruction and exc_* sampled this cycle, and advances PC by 4 (64-bit wrap).
REQ-017 Pop SHALL occur when if_valid && if_ready; if_* outputs SHALL come from FIFO head registers (push-to-visible latency 1 cycle).
REQ-018 Simultaneous push and pop on a full FIFO SHALL both take effect; count unchanged.
REQ-019 Pushed entry with exc_en=1 SHALL store instr 32'h00000013, move state to FAULT, and hold PC; no further push until redirect.
REQ-020 redirect_en SHALL take priority over push and pop: flush FIFO (count=0, if_valid=0 next cycle), PC<=redirect_pc, state<=RUN; no push that cycle.
REQ-021 When FIFO empty, if_valid SHALL be 0 and if_* data fields SHALL be 0.
REQ-022 pc_addr SHALL remain stable while FIFO is full without pop or state is FAULT.

Reset
REQ-023 On rst_n low, asynchronously: PC=RESET_PC, count=0, pointers=0, state=RUN, if_valid=0, all if_* fields 0.
REQ-024 Reset asserted mid-stream SHALL discard all buffered entries and any pending FAULT.
REQ-025 First push SHALL occur on the first rising edge after rst_n deasserts, fetching RESET_PC.

Configuration
REQ-026 With IFETCH_MISALIGN_CHECK_EN defined, a RUN-state PC with pc[1:0]!=0 SHALL push a faulting entry {exc_code=0, exc_val=PC} without using memory response, then enter FAULT.
REQ-027 Without IFETCH_MISALIGN_CHECK_EN, pc[1:0] SHALL be ignored and the memory response used unchanged.

Verification
REQ-028 Reset then if_ready=1, memory returning i0,i1 -> if_valid rises 1 cycle after reset release; if_pc 0x80000000 then 0x80000004, one per cycle.
REQ-029 if_ready=0 for 4 cycles from reset -> count saturates at 2, pc_addr frozen at 0x80000008; if_ready=1 -> entries 0x80000000, 0x80000004, 0x80000008 in order, no loss or duplicate.
REQ-030 FIFO full, redirect_en=1 redirect_pc=0x80000100 with if_ready=1 -> next cycle if_valid=0, then if_pc=0x80000100; no popped entry counted.
REQ-031 Memory exc_en=1 code 1 at pc 0x80040000 -> packet if_exc_en=1, if_exc_code=1, if_exc_val=0x80040000, if_instr=0x00000013; pc_addr held until redirect.
REQ-032 Macro defined, redirect to 0x80000102 -> packet if_exc_code=0, if_exc_val=0x80000102; macro undefined -> normal fetch of word 0x80000100 index.
REQ-033 rst_n low mid-stream with 2 entries buffered and FAULT pending -> immediately if_valid=0, pc_addr=0x80000000.
